// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one uart_tx transmitter between NUM_REQ byte producers (mole-position
// updates, game-over code, score reports, ...). Each producer owns a one-deep
// latest-value slot. Pending slots are granted round-robin, and this block is
// the only driver of tx_start, pacing itself on tx_busy.
//
// Parameters
//   NUM_REQ      number of requester channels (2..8)
//   ACK_TIMEOUT  cycles to wait for tx_busy to rise after tx_start
//
// Ports
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   req_valid       in   [NUM_REQ]     per-channel one-cycle request strobe
//   req_data        in   [8*NUM_REQ]   channel i byte in req_data[8*i+7:8*i]
//   req_pending     out  [NUM_REQ]     slot i holds an unsent byte
//   overflow        out  [NUM_REQ]     sticky: slot i overwritten before sent
//   clear_overflow  in   one-cycle pulse clearing all overflow bits
//   tx_busy         in   uart_tx frame in progress
//   tx_start        out  one-cycle start strobe to uart_tx
//   tx_data         out  [8]  byte to uart_tx, changes only on grant edges
//   grant_id        out  [3]  channel of the byte currently / last sent
//   tx_error        out  sticky: a tx_start saw no tx_busy within ACK_TIMEOUT
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_pending,
  output logic [NUM_REQ-1:0]   overflow,
  input  logic                 clear_overflow,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [2:0]           grant_id,
  output logic                 tx_error
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      rr_q, rr_d;

  logic [7:0]         slot_q [NUM_REQ];
  logic [7:0]         slot_d [NUM_REQ];
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] overflow_q, overflow_d;

  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [2:0]         grant_q, grant_d;
  logic               err_q, err_d;

  logic               grant_vld;
  logic [IW-1:0]      grant_idx;
  logic               ack_timeout;

  // Round-robin pick: first pending channel at or after rr_q, wrapping.
  // A grant is only issued from IDLE; tx_busy is deliberately not consulted.
  always_comb begin
    int unsigned sum;
    logic [IW-1:0] idx;
    sum       = 0;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(rr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = sum[IW-1:0];
      if (!grant_vld && pending_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (state_q != IDLE) grant_vld = 1'b0;
  end

  assign ack_timeout = (state_q == WAIT_ACK) && !tx_busy &&
                       (cnt_q == CW'(ACK_TIMEOUT - 1));

  // Slot update. The grant clears pending first so that a request landing on
  // the grant edge of its own channel reloads the slot without flagging overflow;
  // overflow clear is applied before the sets so a same-edge set wins.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) slot_d[i] = slot_q[i];
    if (grant_vld) pending_d[grant_idx] = 1'b0;
    if (clear_overflow) overflow_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (pending_d[i]) overflow_d[i] = 1'b1;
        slot_d[i]    = req_data[8*i +: 8];
        pending_d[i] = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = WAIT_ACK;
          cnt_d   = '0;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (ack_timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM: output logic (registered outputs, next values)
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    err_d      = err_q;
    if (grant_vld) begin
      tx_start_d = 1'b1;
      tx_data_d  = slot_q[grant_idx];
      grant_d    = 3'(grant_idx);
      rr_d       = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (ack_timeout) err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign req_pending = pending_q;
  assign overflow    = overflow_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign tx_error    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (slots, round-robin pointer, link phase) predicts every
// output after every clock edge; a small uart_tx responder raises tx_busy one
// cycle after tx_start for 20 cycles (or stays silent when disabled).
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int N        = 4;
  localparam int T        = 16;
  localparam int BUSY_LEN = 20;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_pending;
  logic [N-1:0]   overflow;
  logic           clear_overflow;
  logic           tx_busy;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [2:0]     grant_id;
  logic           tx_error;

  always #5 clock = ~clock;

  uart_tx_scheduler #(.NUM_REQ(N), .ACK_TIMEOUT(T)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_pending    (req_pending),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .grant_id       (grant_id),
    .tx_error       (tx_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_slot [N];
  logic [N-1:0] m_pend, m_ovf;
  int         m_rr, m_phase, m_wait, m_gid;
  logic       m_err, m_start;
  logic [7:0] m_data;

  // uart responder state
  logic u_en, u_arm;
  int   u_cnt;

  logic [7:0] obs_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*N-1:0] mk(input int ch, input logic [7:0] b);
    logic [8*N-1:0] r;
    r = '0;
    r[8*ch +: 8] = b;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = '0;
    m_pend = '0; m_ovf = '0; m_rr = 0; m_phase = 0; m_wait = 0;
    m_gid = 0; m_err = 1'b0; m_start = 1'b0; m_data = '0;
  endtask

  // phase: 0 = link free, 1 = start issued awaiting busy, 2 = frame running
  task automatic model_edge(input logic [N-1:0] v, input logic [8*N-1:0] d,
                            input logic clr, input logic busy);
    m_start = 1'b0;
    if (m_phase == 0) begin
      int sel;
      sel = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (sel < 0 && m_pend[c]) sel = c;
      end
      if (sel >= 0) begin
        m_start = 1'b1;
        m_data  = m_slot[sel];
        m_gid   = sel;
        m_pend[sel] = 1'b0;
        m_rr    = (sel + 1) % N;
        m_phase = 1;
        m_wait  = 0;
      end
    end else if (m_phase == 1) begin
      if (busy) m_phase = 2;
      else begin
        m_wait++;
        if (m_wait == T) begin
          m_err   = 1'b1;
          m_phase = 0;
        end
      end
    end else if (!busy) begin
      m_phase = 0;
    end
    if (clr) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_slot[i] = d[8*i +: 8];
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("tx_start",    32'(tx_start),    32'(m_start));
    check("tx_data",     32'(tx_data),     32'(m_data));
    check("grant_id",    32'(grant_id),    32'(m_gid));
    check("req_pending", 32'(req_pending), 32'(m_pend));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("tx_error",    32'(tx_error),    32'(m_err));
  endtask

  task automatic uart_update();
    if (u_arm) begin
      tx_busy = 1'b1;
      u_cnt   = BUSY_LEN;
      u_arm   = 1'b0;
    end else if (tx_busy) begin
      u_cnt--;
      if (u_cnt == 0) tx_busy = 1'b0;
    end
    if (u_en && tx_start === 1'b1) u_arm = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] d, input logic clr);
    logic busy_pre;
    busy_pre       = tx_busy;
    req_valid      = v;
    req_data       = d;
    clear_overflow = clr;
    @(posedge clock);
    #1;
    model_edge(v, d, clr, busy_pre);
    check_all();
    if (tx_start === 1'b1) obs_q.push_back(tx_data);
    uart_update();
    req_valid      = '0;
    clear_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (n) begin
      @(posedge clock);
      #1;
      check_all();
      uart_update();
    end
    reset = 1'b1;
  endtask

  function automatic logic quiet();
    return (m_phase == 0) && (m_pend == '0) && !tx_busy && !u_arm;
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (!quiet() && guard < 400) begin
      idle(1);
      guard++;
    end
    check("drain_done", 32'(quiet()), 32'd1);
  endtask

  initial begin
    reset          = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    clear_overflow = 1'b0;
    tx_busy        = 1'b0;
    u_en           = 1'b1;
    u_arm          = 1'b0;
    u_cnt          = 0;
    do_reset(3);

    // single request on ch1
    obs_q.delete();
    step(4'b0010, mk(1, 8'h33), 1'b0);
    drain();
    check("t1_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) check("t1_byte", 32'(obs_q[0]), 32'h33);
    check("t1_gid", 32'(grant_id), 32'd1);
    check("t1_pend", 32'(req_pending), 32'd0);

    // three same-edge requests from rr_ptr 0
    do_reset(2);
    obs_q.delete();
    step(4'b1101, mk(0, 8'h52) | mk(2, 8'h34) | mk(3, 8'h53), 1'b0);
    drain();
    check("t2_count", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("t2_first",  32'(obs_q[0]), 32'h52);
      check("t2_second", 32'(obs_q[1]), 32'h34);
      check("t2_third",  32'(obs_q[2]), 32'h53);
    end

    // overwrite while busy
    obs_q.delete();
    step(4'b0001, mk(0, 8'h41), 1'b0);
    idle(3);
    step(4'b0010, mk(1, 8'h31), 1'b0);
    step(4'b0010, mk(1, 8'h32), 1'b0);
    check("t3_ovf_set", 32'(overflow[1]), 32'd1);
    drain();
    check("t3_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) check("t3_latest", 32'(obs_q[1]), 32'h32);
    step('0, '0, 1'b1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // request coinciding with its own grant edge
    obs_q.delete();
    step(4'b0001, mk(0, 8'h50), 1'b0);
    idle(2);
    step(4'b0100, mk(2, 8'h36), 1'b0);
    begin
      int g;
      g = 0;
      while (!(m_phase == 0 && m_pend[2]) && g < 200) begin idle(1); g++; end
      check("t4_reach_grant", 32'(m_phase == 0 && m_pend[2]), 32'd1);
    end
    step(4'b0100, mk(2, 8'h35), 1'b0);
    check("t4_pend2", 32'(req_pending[2]), 32'd1);
    check("t4_ovf2",  32'(overflow[2]), 32'd0);
    drain();
    check("t4_count", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check("t4_old", 32'(obs_q[1]), 32'h36);
      check("t4_new", 32'(obs_q[2]), 32'h35);
    end

    // acknowledge timeout
    obs_q.delete();
    u_en = 1'b0;
    step(4'b1000, mk(3, 8'h77), 1'b0);
    idle(T);
    check("t5_err_pending", 32'(tx_error), 32'd0);
    idle(1);
    check("t5_err", 32'(tx_error), 32'd1);
    u_en = 1'b1;
    step(4'b0001, mk(0, 8'h52), 1'b0);
    drain();
    check("t5_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) check("t5_retry", 32'(obs_q[1]), 32'h52);
    check("t5_err_sticky", 32'(tx_error), 32'd1);

    // reset during a frame with slots pending
    obs_q.delete();
    step(4'b0010, mk(1, 8'h61), 1'b0);
    begin
      int g;
      g = 0;
      while (m_phase != 2 && g < 50) begin idle(1); g++; end
      check("t6_in_frame", 32'(m_phase), 32'd2);
    end
    step(4'b1100, mk(2, 8'h62) | mk(3, 8'h63), 1'b0);
    do_reset(2);
    check("t6_pend_zero", 32'(req_pending), 32'd0);
    idle(30);
    check("t6_count", 32'(obs_q.size()), 32'd1);
    step(4'b0100, mk(2, 8'h99), 1'b0);
    drain();
    check("t6_count2", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) check("t6_new", 32'(obs_q[1]), 32'h99);

    // randomized traffic, occasional silent uart and overflow clears
    repeat (600) begin
      logic [N-1:0]   v;
      logic [8*N-1:0] d;
      for (int i = 0; i < N; i++) begin
        v[i]         = ($urandom_range(0, 7) == 0);
        d[8*i +: 8]  = 8'($urandom);
      end
      u_en = ($urandom_range(0, 9) != 0);
      step(v, d, $urandom_range(0, 15) == 0);
    end
    u_en = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
